aa_frame_sequencer: RTL

- Walks a full frame in raster order and produces one anti-aliased RGB pixel per location.
- Time-multiplexes a single shared pixel-fetch port across the 9 taps of a 3x3 neighbourhood.
- Accumulates a 1-2-1 weighted kernel sum per channel and emits the result on a valid/ready stream.
- Sits between the frame/pixel source and the VGA output buffer; replaces nine parallel combinational pixel lookups with one port plus a sequencer.

---
 rtl/aa_pkg.sv | 13 +
 rtl/aa_tap_addr.sv | 23 ++
 rtl/aa_frame_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/aa_pkg.sv
// aa_pkg: kernel tap tables, FSM state type and output rounding for the AA frame sequencer
package aa_pkg;
    localparam int ACC_W = 12;
    localparam int ROUND = 8;
    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;
    localparam logic [1:0] KERNEL_SHIFT [0:8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
    localparam logic signed [1:0] DX [0:8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] DY [0:8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
    // weights sum to 16, so (acc + 8) >> 4 is a round-half-up divide that never exceeds 255
    function automatic logic [7:0] round_out(input logic [ACC_W-1:0] acc);
        return 8'(({1'b0, acc} + (ACC_W + 1)'(ROUND)) >> 4);
    endfunction
endpackage

// File: rtl/aa_tap_addr.sv
// aa_tap_addr: clamps pixel (x,y) plus the tap offset into the frame so edge pixels replicate
// ports: x, y = current pixel; tap = kernel tap 0..8; tap_x, tap_y = clamped fetch coordinate
module aa_tap_addr
    import aa_pkg::*;
#(
    parameter int H_RES = 1024,
    parameter int V_RES = 768
) (
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [3:0]  tap,
    output logic [10:0] tap_x,
    output logic [9:0]  tap_y
);
    logic signed [12:0] sx;
    logic signed [11:0] sy;
    always_comb begin
        sx = $signed({2'b00, x}) + 13'(DX[tap]);
        sy = $signed({2'b00, y}) + 12'(DY[tap]);
        tap_x = sx[12] ? '0 : sx > 13'(H_RES - 1) ? 11'(H_RES - 1) : sx[10:0];
        tap_y = sy[11] ? '0 : sy > 12'(V_RES - 1) ? 10'(V_RES - 1) : sy[9:0];
    end
endmodule

// File: rtl/aa_frame_sequencer.sv
// aa_frame_sequencer: raster walk producing one 3x3 1-2-1 filtered RGB pixel per location over one shared fetch port
// ports: start/busy/frame_done = frame control; fetch_* = tap read port (ack carries data);
//        out_* = valid/ready pixel stream with coordinate
module aa_frame_sequencer
    import aa_pkg::*;
#(
    parameter int H_RES = 1024,
    parameter int V_RES = 768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        fetch_req,
    output logic [10:0] fetch_x,
    output logic [9:0]  fetch_y,
    input  logic        fetch_ack,
    input  logic [7:0]  fetch_r,
    input  logic [7:0]  fetch_g,
    input  logic [7:0]  fetch_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_x,
    output logic [9:0]  out_y,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b
);
    state_t state;
    logic [10:0] x;
    logic [9:0] y;
    logic [3:0] tap;
    logic [ACC_W-1:0] acc_r, acc_g, acc_b, sum_r, sum_g, sum_b;
    logic last, eol;
    // fetch coordinates follow x/y/tap, which only move on ack or emit, so they hold through a pending request
    aa_tap_addr #(.H_RES(H_RES), .V_RES(V_RES)) u_tap_addr (
        .x(x), .y(y), .tap(tap), .tap_x(fetch_x), .tap_y(fetch_y)
    );
    always_comb begin
        sum_r = acc_r + (ACC_W'(fetch_r) << KERNEL_SHIFT[tap]);
        sum_g = acc_g + (ACC_W'(fetch_g) << KERNEL_SHIFT[tap]);
        sum_b = acc_b + (ACC_W'(fetch_b) << KERNEL_SHIFT[tap]);
        eol = x == 11'(H_RES - 1);
        last = eol && y == 10'(V_RES - 1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            frame_done <= 1'b0;
            fetch_req <= 1'b0;
            out_valid <= 1'b0;
            x <= '0;
            y <= '0;
            tap <= '0;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            out_x <= '0;
            out_y <= '0;
            out_r <= '0;
            out_g <= '0;
            out_b <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                // the frame_done cycle is already IDLE; a start there is still treated as arriving while busy
                IDLE: if (start && !frame_done) begin
                    state <= FETCH;
                    busy <= 1'b1;
                    fetch_req <= 1'b1;
                    x <= '0;
                    y <= '0;
                    tap <= '0;
                    acc_r <= '0;
                    acc_g <= '0;
                    acc_b <= '0;
                end
                FETCH: if (fetch_ack) begin
                    acc_r <= sum_r;
                    acc_g <= sum_g;
                    acc_b <= sum_b;
                    if (tap == 4'd8) begin
                        state <= EMIT;
                        fetch_req <= 1'b0;
                        out_valid <= 1'b1;
                        out_x <= x;
                        out_y <= y;
                        out_r <= round_out(sum_r);
                        out_g <= round_out(sum_g);
                        out_b <= round_out(sum_b);
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        state <= FETCH;
                        fetch_req <= 1'b1;
                        tap <= '0;
                        acc_r <= '0;
                        acc_g <= '0;
                        acc_b <= '0;
                        x <= eol ? '0 : x + 11'd1;
                        y <= eol ? y + 10'd1 : y;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
